rom_frame_stats: RTL and testbench

Frame statistics engine that sits directly downstream of the single-port ROM read controller. It consumes the 16-bit word stream read from block RAM and accumulates sum, minimum, maximum and word count over one frame of FRAME_LEN words. Each frame ends either on the last word or on an abort. The final results are registered and announced with a one-cycle strobe, so software or a later stage can sample the statistics of each ROM sweep.

---
 rtl/rom_frame_stats.sv | 125 ++++++++++++
 tb/tb_rom_frame_stats.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_frame_stats.sv
// Frame statistics engine: accumulates sum, min, max and word count over one
// frame of ROM read data and publishes the results with a one-cycle strobe.
module rom_frame_stats #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 100,
    parameter int CNT_W     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    busy,
    output logic                    stat_valid,
    output logic                    frame_err,
    output logic [DATA_W+CNT_W-1:0] sum_out,
    output logic [DATA_W-1:0]       min_out,
    output logic [DATA_W-1:0]       max_out,
    output logic [CNT_W-1:0]        count_out
);

    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
    logic [CNT_W-1:0]  acc_cnt;
    logic              err_pend, err_pend_nxt;

    logic clear, take, last_word;

    assign last_word = (acc_cnt == LAST_IDX);

    // Completion takes priority over abort when both land on the last word.
    always_comb begin
        state_nxt    = state;
        err_pend_nxt = err_pend;
        clear        = 1'b0;
        take         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ACCUM;
                    clear     = 1'b1;
                end
            end
            S_ACCUM: begin
                take = in_valid;
                if (in_valid && last_word) begin
                    state_nxt    = S_DONE;
                    err_pend_nxt = 1'b0;
                end else if (abort) begin
                    state_nxt    = S_DONE;
                    err_pend_nxt = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            err_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_pend <= err_pend_nxt;
        end
    end

    // Working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum <= '0;
            acc_min <= '1;
            acc_max <= '0;
            acc_cnt <= '0;
        end else if (clear) begin
            acc_sum <= '0;
            acc_min <= '1;
            acc_max <= '0;
            acc_cnt <= '0;
        end else if (take) begin
            acc_sum <= acc_sum + {{CNT_W{1'b0}}, in_data};
            acc_min <= (in_data < acc_min) ? in_data : acc_min;
            acc_max <= (in_data > acc_max) ? in_data : acc_max;
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // Result registers load on the edge that leaves DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            stat_valid <= 1'b0;
            frame_err  <= 1'b0;
            sum_out    <= '0;
            min_out    <= '0;
            max_out    <= '0;
            count_out  <= '0;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            stat_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                frame_err <= err_pend;
                sum_out   <= acc_sum;
                min_out   <= acc_min;
                max_out   <= acc_max;
                count_out <= acc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_rom_frame_stats.sv
// Directed bench for rom_frame_stats: queue-based frame model checked every
// cycle, plus literal expectations for each scenario.
module tb_rom_frame_stats;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 100;
    localparam int CNT_W     = 7;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic                    in_valid = 1'b0;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    busy, stat_valid, frame_err;
    logic [DATA_W+CNT_W-1:0] sum_out;
    logic [DATA_W-1:0]       min_out, max_out;
    logic [CNT_W-1:0]        count_out;

    int total = 0;
    int bad   = 0;

    rom_frame_stats #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .stat_valid(stat_valid), .frame_err(frame_err),
        .sum_out(sum_out), .min_out(min_out), .max_out(max_out),
        .count_out(count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is the list of words accepted since start; results are
    // computed from that list when the frame closes.
    int     m_phase = 0;  // 0 idle, 1 collecting, 2 closing
    int     q[$];
    bit     m_err_pend = 0;
    bit     e_busy = 0, e_sv = 0, e_err = 0;
    longint e_sum = 0, e_min = 0, e_max = 0, e_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; q.delete(); m_err_pend = 0;
            e_busy = 0; e_sv = 0; e_err = 0;
            e_sum = 0; e_min = 0; e_max = 0; e_cnt = 0;
        end else begin
            e_sv = 0;
            if (m_phase == 0) begin
                if (start) begin m_phase = 1; q.delete(); end
            end else if (m_phase == 1) begin
                if (in_valid) q.push_back(int'(in_data));
                if (q.size() == FRAME_LEN) begin m_phase = 2; m_err_pend = 0; end
                else if (abort) begin m_phase = 2; m_err_pend = 1; end
            end else begin
                e_sum = 0; e_min = 64'hFFFF; e_max = 0;
                foreach (q[i]) begin
                    e_sum += q[i];
                    if (q[i] < e_min) e_min = q[i];
                    if (q[i] > e_max) e_max = q[i];
                end
                e_cnt = q.size();
                e_err = m_err_pend;
                e_sv = 1;
                m_phase = 0;
            end
            e_busy = (m_phase != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", longint'(busy), longint'(e_busy));
            chk("stat_valid", longint'(stat_valid), longint'(e_sv));
            chk("frame_err", longint'(frame_err), longint'(e_err));
            chk("sum_out", longint'(sum_out), e_sum);
            chk("min_out", longint'(min_out), e_min);
            chk("max_out", longint'(max_out), e_max);
            chk("count_out", longint'(count_out), e_cnt);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends n words first, first+incr, ...; gaps inserts an idle cycle after each.
    task automatic send_words(input int n, input int first, input int incr, input bit gaps);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(first + i * incr);
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the closing edge; returns edges elapsed.
    task automatic wait_stat(input string name, output int lat);
        lat = 1;
        while (!stat_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!stat_valid) begin
            bad++; total++;
            $display("FAIL %s timeout waiting for stat_valid", name);
        end
    endtask

    task automatic chk_res(input string n, input longint s, input longint mn,
                           input longint mx, input longint c, input longint e);
        chk({n, "_sum"}, longint'(sum_out), s);
        chk({n, "_min"}, longint'(min_out), mn);
        chk({n, "_max"}, longint'(max_out), mx);
        chk({n, "_cnt"}, longint'(count_out), c);
        chk({n, "_err"}, longint'(frame_err), e);
    endtask

    initial begin
        int lat;
        #2;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_sv", longint'(stat_valid), 0);
        chk_res("rst", 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stray traffic while idle must not leak into the next frame.
        in_valid = 1'b1; in_data = 16'd500; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;

        // Ramp
        do_start();
        send_words(100, 0, 1, 0);
        wait_stat("ramp", lat);
        chk("ramp_lat", lat, 2);
        chk_res("ramp", 4950, 0, 99, 100, 0);
        @(negedge clk);

        // Saturation with alternating in_valid
        do_start();
        send_words(100, 16'hFFFF, 0, 1);
        wait_stat("sat", lat);
        chk_res("sat", 6553500, 16'hFFFF, 16'hFFFF, 100, 0);
        @(negedge clk);

        // Abort after 10 words
        do_start();
        send_words(10, 5, 1, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_stat("abort", lat);
        chk("abort_lat", lat, 2);
        chk_res("abort", 95, 5, 14, 10, 1);
        @(negedge clk);

        // Full frame clears frame_err
        do_start();
        send_words(100, 0, 1, 0);
        wait_stat("clr", lat);
        chk_res("clr", 4950, 0, 99, 100, 0);
        @(negedge clk);

        // Abort together with the 100th word: completion wins
        do_start();
        send_words(99, 0, 1, 0);
        in_valid = 1'b1; in_data = 16'd99; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        wait_stat("ab100", lat);
        chk_res("ab100", 4950, 0, 99, 100, 0);
        @(negedge clk);

        // Zero-word abort
        do_start();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_stat("ab0", lat);
        chk_res("ab0", 0, 16'hFFFF, 0, 0, 1);
        @(negedge clk);

        // start pulses during ACCUM are ignored
        do_start();
        send_words(50, 0, 1, 0);
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        send_words(50, 50, 1, 0);
        wait_stat("stign", lat);
        chk_res("stign", 4950, 0, 99, 100, 0);
        @(negedge clk);

        // Reset mid-frame
        do_start();
        send_words(50, 0, 1, 0);
        rst = 1'b1;
        #1;
        chk("mrst_busy", longint'(busy), 0);
        chk("mrst_sv", longint'(stat_valid), 0);
        chk_res("mrst", 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_words(100, 1, 1, 0);
        wait_stat("post", lat);
        chk_res("post", 5050, 1, 100, 100, 0);

        // Back-to-back: start in the cycle right after DONE
        @(negedge clk);
        do_start();
        send_words(100, 0, 1, 0);
        wait_stat("b2b1", lat);
        chk_res("b2b1", 4950, 0, 99, 100, 0);
        do_start();
        send_words(100, 0, 1, 0);
        wait_stat("b2b2", lat);
        chk("b2b2_lat", lat, 2);
        chk_res("b2b2", 4950, 0, 99, 100, 0);
        @(negedge clk); @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
